// File: rtl/sram_stage_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_stage_sequencer_if                                         |
// | Purpose  : Decode-stage handshake and shared SRAM bus between the          |
// |            sequencer and its stages / SRAM controller.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface sram_stage_sequencer_if #(
    parameter int N_STAGES = 3,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16
);
    logic [N_STAGES-1:0]        stage_enable;
    logic [N_STAGES-1:0]        stage_done;
    logic [N_STAGES*ADDR_W-1:0] stage_sram_address;
    logic [N_STAGES*DATA_W-1:0] stage_sram_write_data;
    logic [N_STAGES-1:0]        stage_sram_we_n;
    logic [ADDR_W-1:0]          sram_address;
    logic [DATA_W-1:0]          sram_write_data;
    logic                       sram_we_n;

    modport master (
        output stage_enable,
        input  stage_done,
        input  stage_sram_address,
        input  stage_sram_write_data,
        input  stage_sram_we_n,
        output sram_address,
        output sram_write_data,
        output sram_we_n
    );

    modport slave (
        input  stage_enable,
        output stage_done,
        output stage_sram_address,
        output stage_sram_write_data,
        output stage_sram_we_n,
        input  sram_address,
        input  sram_write_data,
        input  sram_we_n
    );
endinterface
`default_nettype wire

// File: rtl/sram_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_stage_sequencer                                            |
// | Purpose  : UART image load, then N decode stages in order, then VGA;       |
// |            arbitrates the SRAM bus. Optional macro STAGE_WATCHDOG_EN adds  |
// |            a per-stage watchdog with a sticky error flag.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_stage_sequencer #(
    parameter int N_STAGES        = 3,
    parameter int ADDR_W          = 18,
    parameter int DATA_W          = 16,
    parameter int TIMER_W         = 26,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int WATCHDOG_CYCLES = 2**24
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_start,
    output logic                   o_uart_rx_initialize,
    output logic                   o_uart_rx_enable,
    input  wire logic [ADDR_W-1:0] i_uart_sram_address,
    input  wire logic [DATA_W-1:0] i_uart_sram_write_data,
    input  wire logic              i_uart_sram_we_n,
    output logic                   o_vga_enable,
    input  wire logic [ADDR_W-1:0] i_vga_sram_address,
    output logic                   o_busy,
    output logic [3:0]             o_active_stage,
    output logic                   o_error,
    sram_stage_sequencer_if.master bus
);
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int N_PAD = 2**IDX_W;

    localparam logic [TIMER_W-1:0] c_timer_max = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   c_last_idx  = IDX_W'(N_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_UART_EN     = 3'd1,
        S_UART_WAIT   = 3'd2,
        S_STAGE_START = 3'd3,
        S_STAGE_RUN   = 3'd4
    } t_state;

    t_state              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [TIMER_W-1:0]  r_timer;
    logic [N_STAGES-1:0] r_stage_enable;
    logic                r_vga_enable;
    logic                r_uart_init;
    logic                r_uart_en;
    logic [3:0]          r_active_stage;

    // Stage slices padded to a power of two so r_idx always indexes in range.
    logic [ADDR_W-1:0] w_stage_addr [N_PAD];
    logic [DATA_W-1:0] w_stage_data [N_PAD];
    logic [N_PAD-1:0]  w_stage_we_n;
    logic [N_PAD-1:0]  w_done_pad;
    logic [N_PAD-1:0]  w_onehot;
    logic              w_done;

    for (genvar gi = 0; gi < N_PAD; gi++) begin : g_slice
        if (gi < N_STAGES) begin : g_used
            assign w_stage_addr[gi] = bus.stage_sram_address[gi*ADDR_W +: ADDR_W];
            assign w_stage_data[gi] = bus.stage_sram_write_data[gi*DATA_W +: DATA_W];
            assign w_stage_we_n[gi] = bus.stage_sram_we_n[gi];
        end else begin : g_pad
            assign w_stage_addr[gi] = '0;
            assign w_stage_data[gi] = '0;
            assign w_stage_we_n[gi] = 1'b1;
        end
    end

    assign w_done_pad = N_PAD'(bus.stage_done);
    assign w_done     = w_done_pad[r_idx];
    assign w_onehot   = N_PAD'(1) << r_idx;

`ifdef STAGE_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] c_wdog_max = WD_W'(WATCHDOG_CYCLES - 1);
    logic [WD_W-1:0] r_wdog;
    logic            r_error;
    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_timer        <= '0;
            r_stage_enable <= '0;
            r_vga_enable   <= 1'b1;
            r_uart_init    <= 1'b0;
            r_uart_en      <= 1'b0;
            r_active_stage <= 4'hF;
`ifdef STAGE_WATCHDOG_EN
            r_wdog         <= '0;
            r_error        <= 1'b0;
`endif
        end else begin
            r_uart_init <= 1'b0;
            r_uart_en   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_vga_enable <= 1'b1;
                    r_timer      <= '0;
                    if (i_start) begin
                        r_uart_init  <= 1'b1;
                        r_vga_enable <= 1'b0;
                        r_state      <= S_UART_EN;
                    end
                end
                S_UART_EN: begin
                    r_uart_en <= 1'b1;
                    r_timer   <= '0;
                    r_state   <= S_UART_WAIT;
                end
                S_UART_WAIT: begin
                    // An empty load (address still 0) keeps waiting after timeout.
                    if (r_timer == c_timer_max && i_uart_sram_address != '0) begin
                        r_uart_init <= 1'b1;
                        r_idx       <= '0;
                        r_timer     <= '0;
                        r_state     <= S_STAGE_START;
                    end else if (r_uart_init || !i_uart_sram_we_n) begin
                        r_timer <= '0;
                    end else if (r_timer != c_timer_max) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STAGE_START: begin
                    r_stage_enable <= w_onehot[N_STAGES-1:0];
                    r_active_stage <= 4'(r_idx);
`ifdef STAGE_WATCHDOG_EN
                    r_wdog         <= '0;
`endif
                    r_state        <= S_STAGE_RUN;
                end
                S_STAGE_RUN: begin
                    if (w_done) begin
                        r_stage_enable <= '0;
                        if (r_idx == c_last_idx) begin
                            r_vga_enable   <= 1'b1;
                            r_active_stage <= 4'hF;
                            r_state        <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_STAGE_START;
                        end
                    end
`ifdef STAGE_WATCHDOG_EN
                    else if (r_wdog == c_wdog_max) begin
                        r_stage_enable <= '0;
                        r_error        <= 1'b1;
                        r_vga_enable   <= 1'b1;
                        r_active_stage <= 4'hF;
                        r_state        <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.sram_address    = i_vga_sram_address;
        bus.sram_write_data = '0;
        bus.sram_we_n       = 1'b1;
        case (r_state)
            S_UART_EN, S_UART_WAIT: begin
                bus.sram_address    = i_uart_sram_address;
                bus.sram_write_data = i_uart_sram_write_data;
                bus.sram_we_n       = i_uart_sram_we_n;
            end
            S_STAGE_START, S_STAGE_RUN: begin
                bus.sram_address    = w_stage_addr[r_idx];
                bus.sram_write_data = w_stage_data[r_idx];
                bus.sram_we_n       = w_stage_we_n[r_idx];
            end
            default: ;
        endcase
    end

    assign bus.stage_enable         = r_stage_enable;
    assign o_uart_rx_initialize     = r_uart_init;
    assign o_uart_rx_enable         = r_uart_en;
    assign o_vga_enable             = r_vga_enable;
    assign o_active_stage           = r_active_stage;
    assign o_busy                   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_stage_sequencer                                         |
// | Purpose  : Directed self-checking bench, 3 stages, 16-cycle UART timeout.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_stage_sequencer;
    localparam int N_STAGES = 3;
    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 16;
    localparam logic [17:0] c_vga_addr = 18'h2_AAAA;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        o_uart_rx_initialize;
    logic        o_uart_rx_enable;
    logic [17:0] i_uart_sram_address;
    logic [15:0] i_uart_sram_write_data;
    logic        i_uart_sram_we_n;
    logic        o_vga_enable;
    logic [17:0] i_vga_sram_address;
    logic        o_busy;
    logic [3:0]  o_active_stage;
    logic        o_error;

    int checks = 0;
    int errors = 0;

    sram_stage_sequencer_if #(.N_STAGES(N_STAGES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_stage_sequencer #(
        .N_STAGES(N_STAGES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMER_W(26),
        .TIMEOUT_CYCLES(16), .WATCHDOG_CYCLES(32)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .o_uart_rx_initialize(o_uart_rx_initialize), .o_uart_rx_enable(o_uart_rx_enable),
        .i_uart_sram_address(i_uart_sram_address), .i_uart_sram_write_data(i_uart_sram_write_data),
        .i_uart_sram_we_n(i_uart_sram_we_n), .o_vga_enable(o_vga_enable),
        .i_vga_sram_address(i_vga_sram_address), .o_busy(o_busy),
        .o_active_stage(o_active_stage), .o_error(o_error), .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start, one UART word, then idle until stage 0 is running.
    task automatic load_to_stage0();
        i_start = 1'b1; step(); i_start = 1'b0; step();
        i_uart_sram_address = 18'd7; i_uart_sram_we_n = 1'b0; step();
        i_uart_sram_we_n = 1'b1;
        repeat (16) step();
        step();
    endtask

    task automatic run_chain_quick();
        bus.stage_done = 3'b001; step(); bus.stage_done = 3'b000; step();
        bus.stage_done = 3'b010; step(); bus.stage_done = 3'b000; step();
        bus.stage_done = 3'b100; step(); bus.stage_done = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0;
        i_uart_sram_address = '0; i_uart_sram_write_data = '0; i_uart_sram_we_n = 1'b1;
        i_vga_sram_address = c_vga_addr;
        bus.stage_done = '0;
        bus.stage_sram_address    = {18'h3_0002, 18'h3_0001, 18'h3_0000};
        bus.stage_sram_write_data = {16'hC002, 16'hC001, 16'hC000};
        bus.stage_sram_we_n       = 3'b101;
        step(); step(); rst = 1'b0; step();
        checks++;
        if ({o_vga_enable, o_busy, o_uart_rx_initialize, o_uart_rx_enable, o_error} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 10000", {o_vga_enable, o_busy, o_uart_rx_initialize, o_uart_rx_enable, o_error});
        end
        checks++;
        if ({bus.stage_enable, o_active_stage} !== {3'b000, 4'hF}) begin
            errors++; $display("FAIL reset_stage: got en=%b act=%h want en=000 act=f", bus.stage_enable, o_active_stage);
        end
        checks++;
        if ({bus.sram_address, bus.sram_write_data, bus.sram_we_n} !== {c_vga_addr, 16'h0000, 1'b1}) begin
            errors++; $display("FAIL reset_bus: got a=%h d=%h we_n=%b want a=%h d=0 we_n=1", bus.sram_address, bus.sram_write_data, bus.sram_we_n, c_vga_addr);
        end
    endtask

    task automatic test_load();
        i_start = 1'b1; step(); i_start = 1'b0;
        checks++;
        if ({o_uart_rx_initialize, o_uart_rx_enable, o_vga_enable, o_busy} !== 4'b1001) begin
            errors++; $display("FAIL load_cycle1: got %b want 1001", {o_uart_rx_initialize, o_uart_rx_enable, o_vga_enable, o_busy});
        end
        step();
        checks++;
        if ({o_uart_rx_initialize, o_uart_rx_enable} !== 2'b01) begin
            errors++; $display("FAIL load_cycle2: got %b want 01", {o_uart_rx_initialize, o_uart_rx_enable});
        end
        for (int k = 0; k < 4; k++) begin
            i_uart_sram_address = 18'(k); i_uart_sram_write_data = 16'hA000 + 16'(k); i_uart_sram_we_n = 1'b0;
            #1;
            checks++;
            if ({bus.sram_address, bus.sram_write_data, bus.sram_we_n} !== {18'(k), 16'hA000 + 16'(k), 1'b0}) begin
                errors++; $display("FAIL load_mux%0d: got a=%h d=%h we_n=%b want a=%h d=%h we_n=0", k, bus.sram_address, bus.sram_write_data, bus.sram_we_n, 18'(k), 16'hA000 + 16'(k));
            end
            step();
        end
        i_uart_sram_we_n = 1'b1;
        repeat (15) step();
        checks++;
        if ({o_busy, o_uart_rx_initialize, bus.stage_enable, bus.sram_address} !== {1'b1, 1'b0, 3'b000, 18'd3}) begin
            errors++; $display("FAIL load_idle15: got busy=%b init=%b en=%b a=%h want 1 0 000 3", o_busy, o_uart_rx_initialize, bus.stage_enable, bus.sram_address);
        end
        step();
        checks++;
        if ({o_uart_rx_initialize, bus.stage_enable, bus.sram_address} !== {1'b1, 3'b000, 18'h3_0000}) begin
            errors++; $display("FAIL load_exit: got init=%b en=%b a=%h want 1 000 30000", o_uart_rx_initialize, bus.stage_enable, bus.sram_address);
        end
        step();
        checks++;
        if ({bus.stage_enable, o_active_stage, bus.sram_we_n} !== {3'b001, 4'h0, 1'b1}) begin
            errors++; $display("FAIL stage0_start: got en=%b act=%h we_n=%b want 001 0 1", bus.stage_enable, o_active_stage, bus.sram_we_n);
        end
    endtask

    task automatic test_stray_handshakes();
        bus.stage_done = 3'b100; i_start = 1'b1; step();
        bus.stage_done = 3'b000; i_start = 1'b0;
        checks++;
        if ({bus.stage_enable, o_active_stage, o_uart_rx_initialize, o_busy} !== {3'b001, 4'h0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL stray: got en=%b act=%h init=%b busy=%b want 001 0 0 1", bus.stage_enable, o_active_stage, o_uart_rx_initialize, o_busy);
        end
    endtask

    task automatic test_stage_chain();
        repeat (8) step();
        checks++;
        if (bus.stage_enable !== 3'b001) begin
            errors++; $display("FAIL chain_hold0: got %b want 001", bus.stage_enable);
        end
        bus.stage_done = 3'b001; step(); bus.stage_done = 3'b000;
        checks++;
        if ({bus.stage_enable, o_busy, bus.sram_address} !== {3'b000, 1'b1, 18'h3_0001}) begin
            errors++; $display("FAIL chain_gap01: got en=%b busy=%b a=%h want 000 1 30001", bus.stage_enable, o_busy, bus.sram_address);
        end
        step();
        checks++;
        if ({bus.stage_enable, o_active_stage, bus.sram_we_n, bus.sram_write_data} !== {3'b010, 4'h1, 1'b0, 16'hC001}) begin
            errors++; $display("FAIL chain_stage1: got en=%b act=%h we_n=%b d=%h want 010 1 0 c001", bus.stage_enable, o_active_stage, bus.sram_we_n, bus.sram_write_data);
        end
        repeat (4) step();
        bus.stage_done = 3'b010; step(); bus.stage_done = 3'b000;
        checks++;
        if (bus.stage_enable !== 3'b000) begin
            errors++; $display("FAIL chain_gap12: got %b want 000", bus.stage_enable);
        end
        step();
        checks++;
        if ({bus.stage_enable, o_active_stage, bus.sram_address, bus.sram_we_n} !== {3'b100, 4'h2, 18'h3_0002, 1'b1}) begin
            errors++; $display("FAIL chain_stage2: got en=%b act=%h a=%h we_n=%b want 100 2 30002 1", bus.stage_enable, o_active_stage, bus.sram_address, bus.sram_we_n);
        end
        bus.stage_done = 3'b100; step(); bus.stage_done = 3'b000;
        checks++;
        if ({o_vga_enable, o_busy, bus.stage_enable, o_active_stage, bus.sram_address, bus.sram_we_n} !== {1'b1, 1'b0, 3'b000, 4'hF, c_vga_addr, 1'b1}) begin
            errors++; $display("FAIL chain_done: got vga=%b busy=%b en=%b act=%h a=%h we_n=%b want 1 0 000 f %h 1", o_vga_enable, o_busy, bus.stage_enable, o_active_stage, bus.sram_address, bus.sram_we_n, c_vga_addr);
        end
    endtask

    task automatic test_empty_load();
        i_uart_sram_address = '0; i_uart_sram_we_n = 1'b1;
        i_start = 1'b1; step(); i_start = 1'b0; step();
        repeat (40) step();
        checks++;
        if ({o_busy, o_vga_enable, o_uart_rx_initialize, bus.stage_enable, bus.sram_address} !== {1'b1, 1'b0, 1'b0, 3'b000, 18'd0}) begin
            errors++; $display("FAIL empty_load: got busy=%b vga=%b init=%b en=%b a=%h want 1 0 0 000 0", o_busy, o_vga_enable, o_uart_rx_initialize, bus.stage_enable, bus.sram_address);
        end
        i_uart_sram_address = 18'd5; step();
        checks++;
        if (o_uart_rx_initialize !== 1'b1) begin
            errors++; $display("FAIL empty_recover: got init=%b want 1", o_uart_rx_initialize);
        end
        step();
    endtask

    task automatic test_reset_mid_stage();
        bus.stage_done = 3'b001; step(); bus.stage_done = 3'b000; step();
        checks++;
        if ({bus.stage_enable, bus.sram_we_n} !== {3'b010, 1'b0}) begin
            errors++; $display("FAIL midrst_pre: got en=%b we_n=%b want 010 0", bus.stage_enable, bus.sram_we_n);
        end
        rst = 1'b1; #1;
        checks++;
        if ({bus.stage_enable, o_vga_enable, bus.sram_we_n, o_busy, o_active_stage} !== {3'b000, 1'b1, 1'b1, 1'b0, 4'hF}) begin
            errors++; $display("FAIL midrst: got en=%b vga=%b we_n=%b busy=%b act=%h want 000 1 1 0 f", bus.stage_enable, o_vga_enable, bus.sram_we_n, o_busy, o_active_stage);
        end
        step(); rst = 1'b0; step();
    endtask

    task automatic test_watchdog();
        load_to_stage0();
        checks++;
        if (bus.stage_enable !== 3'b001) begin
            errors++; $display("FAIL wd_run: got en=%b want 001", bus.stage_enable);
        end
`ifdef STAGE_WATCHDOG_EN
        repeat (31) step();
        checks++;
        if ({bus.stage_enable, o_error} !== {3'b001, 1'b0}) begin
            errors++; $display("FAIL wd_before: got en=%b err=%b want 001 0", bus.stage_enable, o_error);
        end
        step();
        checks++;
        if ({bus.stage_enable, o_error, o_vga_enable, o_busy} !== {3'b000, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wd_fire: got en=%b err=%b vga=%b busy=%b want 000 1 1 0", bus.stage_enable, o_error, o_vga_enable, o_busy);
        end
        load_to_stage0();
        run_chain_quick();
        checks++;
        if ({o_busy, o_error, o_vga_enable} !== 3'b011) begin
            errors++; $display("FAIL wd_sticky: got busy=%b err=%b vga=%b want 0 1 1", o_busy, o_error, o_vga_enable);
        end
`else
        repeat (40) step();
        checks++;
        if ({bus.stage_enable, o_error, o_busy} !== {3'b001, 1'b0, 1'b1}) begin
            errors++; $display("FAIL nowd_wait: got en=%b err=%b busy=%b want 001 0 1", bus.stage_enable, o_error, o_busy);
        end
        run_chain_quick();
        checks++;
        if ({o_busy, o_error, o_vga_enable} !== 3'b001) begin
            errors++; $display("FAIL nowd_done: got busy=%b err=%b vga=%b want 0 0 1", o_busy, o_error, o_vga_enable);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_stray_handshakes();
        test_stage_chain();
        test_empty_load();
        test_reset_mid_stage();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
